// File: rtl/dispense_pkg.sv
// Shared types and constants for the dispense scheduler: FSM states, time field
// widths and the factory slot table.
package dispense_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic              en;
        logic [HOUR_W-1:0] h;
        logic [MIN_W-1:0]  m;
        logic [SEC_W-1:0]  s;
        logic [MAX_CH-1:0] mask;
    } slot_entry_t;

    localparam slot_entry_t DEF_SLOT0    = '{en: 1'b1, h: 5'd8,  m: 6'd0, s: 6'd0, mask: 8'hff};
    localparam slot_entry_t DEF_SLOT1    = '{en: 1'b1, h: 5'd13, m: 6'd0, s: 6'd0, mask: 8'hff};
    localparam slot_entry_t DEF_SLOT2    = '{en: 1'b1, h: 5'd20, m: 6'd0, s: 6'd0, mask: 8'hff};
    localparam slot_entry_t DEF_SLOT_OFF = '{en: 1'b0, h: 5'd0,  m: 6'd0, s: 6'd0, mask: 8'h00};

    // Slots beyond the original three come up blank and disabled.
    function automatic slot_entry_t default_slot(input int idx);
        case (idx)
            0:       return DEF_SLOT0;
            1:       return DEF_SLOT1;
            2:       return DEF_SLOT2;
            default: return DEF_SLOT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/dispense_slot_match.sv
// One programmable slot: entry register, time comparator and rising-edge event
// detector, so a slot fires once per occurrence even if the time is held.
module dispense_slot_match
    import dispense_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SLOT_IDX = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              cfg_en,
    input  logic [HOUR_W-1:0] cfg_hours,
    input  logic [MIN_W-1:0]  cfg_minutes,
    input  logic [SEC_W-1:0]  cfg_seconds,
    input  logic [NUM_CH-1:0] cfg_mask,
    input  logic [HOUR_W-1:0] hours,
    input  logic [MIN_W-1:0]  minutes,
    input  logic [SEC_W-1:0]  seconds,
    input  logic              time_valid,
    output logic              fire,
    output logic [NUM_CH-1:0] mask,
    output logic              slot_hit
);

    localparam slot_entry_t       DEF      = default_slot(SLOT_IDX);
    localparam logic [NUM_CH-1:0] DEF_MASK = DEF.mask[NUM_CH-1:0];

    logic              en_q, en_d;
    logic [HOUR_W-1:0] h_q, h_d;
    logic [MIN_W-1:0]  m_q, m_d;
    logic [SEC_W-1:0]  s_q, s_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              match_q, match_d;
    logic              hit_q, hit_d;
    logic              match;

    always_comb begin
        en_d   = en_q;
        h_d    = h_q;
        m_d    = m_q;
        s_d    = s_q;
        mask_d = mask_q;
        if (wr_en) begin
            en_d   = cfg_en;
            h_d    = cfg_hours;
            m_d    = cfg_minutes;
            s_d    = cfg_seconds;
            mask_d = cfg_mask;
        end
        // Compare against the stored entry, so a same-cycle write is seen one cycle later.
        match   = en_q && (hours == h_q) && (minutes == m_q) && (seconds == s_q);
        fire    = match && !match_q && time_valid;
        match_d = match;
        hit_d   = fire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q    <= DEF.en;
            h_q     <= DEF.h;
            m_q     <= DEF.m;
            s_q     <= DEF.s;
            mask_q  <= DEF_MASK;
            match_q <= 1'b1;
            hit_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            mask_q  <= mask_d;
            match_q <= match_d;
            hit_q   <= hit_d;
        end
    end

    assign mask     = mask_q;
    assign slot_hit = hit_q;

endmodule

// File: rtl/dispense_scheduler.sv
// Dispense scheduler: slot table, per-channel request queue, round-robin arbiter
// and pulse/gap FSM that powers at most one actuator at a time.
module dispense_scheduler
    import dispense_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int NUM_SLOTS  = 3,
    parameter int PULSE_SECS = 1,
    parameter int GAP_SECS   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sec_tick,
    input  logic [HOUR_W-1:0]    hours,
    input  logic [MIN_W-1:0]     minutes,
    input  logic [SEC_W-1:0]     seconds,
    input  logic                 time_valid,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_slot,
    input  logic [HOUR_W-1:0]    cfg_hours,
    input  logic [MIN_W-1:0]     cfg_minutes,
    input  logic [SEC_W-1:0]     cfg_seconds,
    input  logic [NUM_CH-1:0]    cfg_mask,
    input  logic                 cfg_en,
    input  logic [NUM_CH-1:0]    manual_req,
    input  logic                 overflow_clr,
    output logic [NUM_CH-1:0]    dispense_out,
    output logic [NUM_CH-1:0]    pending,
    output logic                 busy,
    output logic [NUM_SLOTS-1:0] slot_hit,
    output logic [NUM_CH-1:0]    overflow
);

    localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_MAX = (PULSE_SECS > GAP_SECS) ? PULSE_SECS : GAP_SECS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_SECS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_SECS > 0) ? GAP_SECS - 1 : 0);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overflow_q, overflow_d;

    logic [NUM_SLOTS-1:0] slot_fire;
    logic [NUM_CH-1:0]    slot_mask [NUM_SLOTS];
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    grant_vec;
    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;

    // Slot indices >= NUM_SLOTS match no instance, so such writes are dropped.
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        dispense_slot_match #(
            .NUM_CH  (NUM_CH),
            .SLOT_IDX(s)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .wr_en      (cfg_we && (cfg_slot == 3'(s))),
            .cfg_en     (cfg_en),
            .cfg_hours  (cfg_hours),
            .cfg_minutes(cfg_minutes),
            .cfg_seconds(cfg_seconds),
            .cfg_mask   (cfg_mask),
            .hours      (hours),
            .minutes    (minutes),
            .seconds    (seconds),
            .time_valid (time_valid),
            .fire       (slot_fire[s]),
            .mask       (slot_mask[s]),
            .slot_hit   (slot_hit[s])
        );
    end

    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return PTR_W'(sum);
    endfunction

    always_comb begin
        req = manual_req;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_fire[s]) req = req | slot_mask[s];
        end
    end

    // Scan downward so the last hit wins: the nearest pending channel at or after the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[rot_idx(ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = rot_idx(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        grant_vec = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    grant_vec[grant_idx] = 1'b1;
                    ch_d    = grant_idx;
                    ptr_d   = rot_idx(grant_idx, 1);
                    cnt_d   = '0;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                if (sec_tick) begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_d   = '0;
                        state_d = (GAP_SECS == 0) ? IDLE : GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (sec_tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A request for the channel being granted right now is simply re-queued.
        pending_d  = (pending_q & ~grant_vec) | req;
        overflow_d = (overflow_q & ~{NUM_CH{overflow_clr}}) | (req & pending_q & ~grant_vec);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ch_q       <= '0;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        dispense_out = '0;
        if (state_q == FIRE) dispense_out[ch_q] = 1'b1;
    end

    assign busy     = (state_q != IDLE);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Bench for dispense_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a seconds-of-day / time-remaining reference model.
module tb_dispense_scheduler;

    localparam int NC = 4;
    localparam int NS = 3;
    localparam int PS = 1;
    localparam int GS = 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          sec_tick;
    logic [4:0]    hours;
    logic [5:0]    minutes;
    logic [5:0]    seconds;
    logic          time_valid;
    logic          cfg_we;
    logic [2:0]    cfg_slot;
    logic [4:0]    cfg_hours;
    logic [5:0]    cfg_minutes;
    logic [5:0]    cfg_seconds;
    logic [NC-1:0] cfg_mask;
    logic          cfg_en;
    logic [NC-1:0] manual_req;
    logic          overflow_clr;
    logic [NC-1:0] dispense_out;
    logic [NC-1:0] pending;
    logic          busy;
    logic [NS-1:0] slot_hit;
    logic [NC-1:0] overflow;

    dispense_scheduler #(
        .NUM_CH    (NC),
        .NUM_SLOTS (NS),
        .PULSE_SECS(PS),
        .GAP_SECS  (GS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sec_tick    (sec_tick),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .time_valid  (time_valid),
        .cfg_we      (cfg_we),
        .cfg_slot    (cfg_slot),
        .cfg_hours   (cfg_hours),
        .cfg_minutes (cfg_minutes),
        .cfg_seconds (cfg_seconds),
        .cfg_mask    (cfg_mask),
        .cfg_en      (cfg_en),
        .manual_req  (manual_req),
        .overflow_clr(overflow_clr),
        .dispense_out(dispense_out),
        .pending     (pending),
        .busy        (busy),
        .slot_hit    (slot_hit),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: slot times as seconds-of-day, FIRE/GAP as seconds remaining.
    bit            m_en   [NS];
    int            m_time [NS];
    logic [NC-1:0] m_mask [NS];
    bit            m_prev [NS];
    logic [NC-1:0] m_pend;
    logic [NC-1:0] m_ovf;
    logic [NS-1:0] m_hit;
    int            m_phase;  // 0 idle, 1 firing, 2 quiet gap
    int            m_cur;
    int            m_next;
    int            m_left;

    int            obs_q [$];
    int            exp_q [$];
    int            hit_cnt [NS];
    logic [NC-1:0] prev_out = '0;
    int            tick_phase = 0;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_en[s]   = (s < 3);
            m_time[s] = (s == 0) ? 8 * 3600 : (s == 1) ? 13 * 3600 : (s == 2) ? 20 * 3600 : 0;
            m_mask[s] = (s < 3) ? '1 : '0;
            m_prev[s] = 1'b1;
        end
        m_pend  = '0;
        m_ovf   = '0;
        m_hit   = '0;
        m_phase = 0;
        m_cur   = 0;
        m_next  = 0;
        m_left  = 0;
    endtask

    task automatic model_step();
        int            now;
        int            grant;
        bit            match [NS];
        logic [NC-1:0] req;
        if (reset) begin
            model_reset();
            return;
        end
        now = int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds);
        req = manual_req;
        m_hit = '0;
        for (int s = 0; s < NS; s++) begin
            match[s] = m_en[s] && (m_time[s] == now);
            if (match[s] && !m_prev[s] && time_valid) begin
                m_hit[s] = 1'b1;
                req = req | m_mask[s];
            end
        end
        grant = -1;
        if (m_phase == 0) begin
            for (int i = 0; i < NC; i++) begin
                if (grant < 0 && m_pend[(m_next + i) % NC]) grant = (m_next + i) % NC;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (req[c] && m_pend[c] && c != grant) m_ovf[c] = 1'b1;
            else if (overflow_clr) m_ovf[c] = 1'b0;
        end
        if (grant >= 0) m_pend[grant] = 1'b0;
        m_pend = m_pend | req;
        case (m_phase)
            0: if (grant >= 0) begin
                m_phase = 1;
                m_cur   = grant;
                m_next  = (grant + 1) % NC;
                m_left  = PS;
            end
            1: if (sec_tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = (GS == 0) ? 0 : 2;
                    m_left  = GS;
                end
            end
            default: if (sec_tick) begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
        if (cfg_we && int'(cfg_slot) < NS) begin
            m_en[cfg_slot]   = cfg_en;
            m_time[cfg_slot] = int'(cfg_hours) * 3600 + int'(cfg_minutes) * 60 + int'(cfg_seconds);
            m_mask[cfg_slot] = cfg_mask;
        end
        for (int s = 0; s < NS; s++) m_prev[s] = match[s];
    endtask

    task automatic cycle();
        logic [NC-1:0] exp_out;
        model_step();
        @(posedge clock);
        #1;
        exp_out = (m_phase == 1) ? NC'(1 << m_cur) : '0;
        check_eq("dispense_out", 32'(dispense_out), 32'(exp_out));
        check_eq("pending", 32'(pending), 32'(m_pend));
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("slot_hit", 32'(slot_hit), 32'(m_hit));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("onehot0", 32'($onehot0(dispense_out)), 32'd1);
        if (dispense_out != '0 && dispense_out != prev_out) begin
            for (int c = 0; c < NC; c++) if (dispense_out[c]) obs_q.push_back(c);
        end
        prev_out = dispense_out;
        for (int s = 0; s < NS; s++) if (slot_hit[s]) hit_cnt[s]++;
        manual_req   = '0;
        cfg_we       = 1'b0;
        overflow_clr = 1'b0;
        sec_tick     = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick   = (tick_phase == 3);
            tick_phase = (tick_phase + 1) % 4;
            cycle();
        end
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = budget;
        while ((busy || pending != '0) && b > 0) begin
            run(1);
            b--;
        end
        check_eq("idle_in_budget", 32'(busy || pending != '0), 32'd0);
    endtask

    task automatic check_grants(input string tag);
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq({tag, "_order"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 5'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    task automatic pick_time(input int k, output int h, output int m, output int s);
        case (k)
            0:       begin h = 7;  m = 59; s = 59; end
            1:       begin h = 8;  m = 0;  s = 0;  end
            2:       begin h = 12; m = 59; s = 59; end
            3:       begin h = 13; m = 0;  s = 0;  end
            4:       begin h = 20; m = 0;  s = 0;  end
            default: begin h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59); end
        endcase
    endtask

    task automatic clear_hits();
        for (int s = 0; s < NS; s++) hit_cnt[s] = 0;
    endtask

    initial begin
        int h, m, s;
        reset = 1'b1; sec_tick = 1'b0; time_valid = 1'b0;
        set_time(0, 0, 0);
        cfg_we = 1'b0; cfg_slot = '0; cfg_hours = '0; cfg_minutes = '0; cfg_seconds = '0;
        cfg_mask = '0; cfg_en = 1'b0; manual_req = '0; overflow_clr = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        obs_q.delete();
        clear_hits();

        // Default slot0 at 08:00:00 serves all four channels in order.
        time_valid = 1'b1;
        set_time(7, 59, 59);
        cycle();
        set_time(8, 0, 0);
        cycle();
        wait_idle(200);
        check_eq("s1_hit0", 32'(hit_cnt[0]), 32'd1);
        exp_q = '{0, 1, 2, 3};
        check_grants("s1_grants");

        // Reprogrammed slot1 serves only ch2 and does not refire while held.
        clear_hits();
        cfg_we = 1'b1; cfg_slot = 3'd1; cfg_hours = 5'd10; cfg_minutes = 6'd15; cfg_seconds = 6'd30;
        cfg_mask = 4'b0100; cfg_en = 1'b1;
        cycle();
        set_time(10, 15, 29);
        cycle();
        set_time(10, 15, 30);
        cycle();
        run(12);
        wait_idle(200);
        check_eq("s2_hit1", 32'(hit_cnt[1]), 32'd1);
        exp_q = '{2};
        check_grants("s2_grants");

        // Double manual request on a pending channel sets overflow.
        manual_req = 4'b0001;
        cycle();
        cycle();
        manual_req = 4'b0010;
        cycle();
        manual_req = 4'b0010;
        cycle();
        check_eq("s3_ovf_set", 32'(overflow[1]), 32'd1);
        wait_idle(200);
        exp_q = '{0, 1};
        check_grants("s3_grants");
        overflow_clr = 1'b1;
        cycle();
        check_eq("s3_ovf_clr", 32'(overflow[1]), 32'd0);

        // Pointer sits at 2: ch3 must win over ch0.
        manual_req = 4'b1001;
        cycle();
        wait_idle(200);
        exp_q = '{3, 0};
        check_grants("s4_grants");

        // Slot time reached while time is invalid never fires.
        clear_hits();
        time_valid = 1'b0;
        set_time(12, 59, 59);
        cycle();
        set_time(13, 0, 0);
        cycle();
        run(4);
        time_valid = 1'b1;
        run(8);
        check_eq("s5_hits", 32'(hit_cnt[0] + hit_cnt[1] + hit_cnt[2]), 32'd0);
        check_grants("s5_grants");

        // Reset in the middle of a pulse.
        manual_req = 4'b0110;
        cycle();
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check_eq("s6_out_rst", 32'(dispense_out), 32'd0);
        check_eq("s6_pend_rst", 32'(pending), 32'd0);
        reset = 1'b0;
        obs_q.delete();
        clear_hits();
        set_time(12, 59, 59);
        cycle();
        set_time(13, 0, 0);
        cycle();
        wait_idle(200);
        check_eq("s6_default_slot1", 32'(hit_cnt[1]), 32'd1);
        exp_q = '{0, 1, 2, 3};
        check_grants("s6_grants");

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pick_time($urandom_range(0, 5), h, m, s);
                set_time(h, m, s);
            end
            time_valid   = ($urandom_range(0, 15) != 0);
            manual_req   = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
            overflow_clr = ($urandom_range(0, 15) == 0);
            sec_tick     = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 39) == 0) begin
                pick_time($urandom_range(0, 5), h, m, s);
                cfg_we      = 1'b1;
                cfg_slot    = 3'($urandom_range(0, 7));
                cfg_hours   = 5'(h);
                cfg_minutes = 6'(m);
                cfg_seconds = 6'(s);
                cfg_mask    = NC'($urandom);
                cfg_en      = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
